qspi_psram_target: RTL and testbench

- QSPI responder (target) for the on-chip PSRAM check path, at the opposite end of the link from the qspi_if initiator.
- Decodes QPI-mode command, address and data nibbles on sio_i.
- Holds a byte-wide internal memory and returns read data on sio_o/sio_oe.
- sck, ce_n and sio_i are generated in the clk domain, so there are no synchronizers. Edges are detected by oversampling sck with clk.

---
 rtl/qspi_psram_target.sv | 235 +++++++++++++++++++++++
 tb/tb_qspi_psram_target.sv | 323 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/qspi_psram_target.sv
// qspi_psram_target
//   QPI-mode QSPI responder for the on-chip PSRAM check path. It decodes
//   command, address and data nibbles on sio_i and holds a byte-wide
//   internal memory of 2^ADR_W bytes. Read data is returned on
//   sio_o/sio_oe. sck, ce_n and sio_i are generated in the clk domain, so
//   sck edges are found by oversampling with clk (no synchronizers).
//
//   Commands: 0xEB quad read (24-bit address, WAIT_CYC dummy cycles),
//             0x38 quad write (24-bit address), anything else is skipped.
//   Optional: define QSPI_PSRAM_TARGET_READID_EN to answer 0x9F with
//             MFID, KGD, then 0x00 until ce_n rises.
//
// Ports
//   clk     in   system clock
//   rst     in   asynchronous active-high reset
//   sck     in   serial clock from initiator, idle low
//   ce_n    in   chip enable, active low
//   sio_i   in   [3:0] quad data from initiator
//   sio_o   out  [3:0] quad data to initiator
//   sio_oe  out  high while the target drives sio_o
//   busy    out  high while not idle
module qspi_psram_target #(
  parameter int unsigned ADR_W    = 16,
  parameter int unsigned WAIT_CYC = 6,
  parameter logic [7:0]  MFID     = 8'h0D,
  parameter logic [7:0]  KGD      = 8'h5D
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       sck,
  input  logic       ce_n,
  input  logic [3:0] sio_i,
  output logic [3:0] sio_o,
  output logic       sio_oe,
  output logic       busy
);

  typedef enum logic [2:0] {
    IDLE,
    CMD,
    ADR,
    WAIT,
    RDATA,
    WDATA,
    SKIP
  } state_t;

  state_t state, state_nxt;

  logic             sck_d;
  logic             rise, fall;
  logic [7:0]       cnt;
  logic [3:0]       cmd_hi;
  logic [7:0]       cmd_byte;
  logic [ADR_W-1:0] adr;
  logic [ADR_W-1:0] adr_shift;
  logic [ADR_W-1:0] adr_inc;
  logic             is_write;
  logic             id_mode;
  logic [1:0]       id_idx;
  logic             half;
  logic [7:0]       rd_byte;
  logic [3:0]       wr_hi;
  logic             cmd_last, adr_last, wait_last;
  logic             mem_we;

  logic [7:0] mem [0:(2**ADR_W)-1];

  function automatic logic [7:0] id_byte(input logic [1:0] idx);
    case (idx)
      2'd0:    id_byte = MFID;
      2'd1:    id_byte = KGD;
      default: id_byte = 8'h00;
    endcase
  endfunction

  assign rise      = sck & ~sck_d;
  assign fall      = ~sck & sck_d;
  assign cmd_byte  = {cmd_hi, sio_i};
  // Only the low ADR_W bits of the 24-bit address are kept; upper
  // nibbles simply shift out of the register.
  assign adr_shift = {adr[ADR_W-5:0], sio_i};
  assign adr_inc   = adr + ADR_W'(1);
  assign cmd_last  = (state == CMD)  && rise && (cnt == 8'd1);
  assign adr_last  = (state == ADR)  && rise && (cnt == 8'd5);
  assign wait_last = (state == WAIT) && rise && (cnt == 8'(WAIT_CYC - 1));
  // ce_n high wins over a coincident sck rise, so a pending byte is dropped.
  assign mem_we    = (state == WDATA) && !ce_n && rise && half;
  assign busy      = (state != IDLE);

  always_comb begin
    state_nxt = state;
    if (ce_n) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE: state_nxt = CMD;
        CMD: begin
          if (cmd_last) begin
            case (cmd_byte)
              8'hEB, 8'h38: state_nxt = ADR;
`ifdef QSPI_PSRAM_TARGET_READID_EN
              8'h9F:        state_nxt = RDATA;
`endif
              default:      state_nxt = SKIP;
            endcase
          end
        end
        ADR: begin
          if (adr_last) begin
            if (is_write)           state_nxt = WDATA;
            else if (WAIT_CYC == 0) state_nxt = RDATA;
            else                    state_nxt = WAIT;
          end
        end
        WAIT:    if (wait_last) state_nxt = RDATA;
        default: state_nxt = state;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sck_d    <= 1'b0;
      cnt      <= '0;
      cmd_hi   <= '0;
      adr      <= '0;
      is_write <= 1'b0;
      id_mode  <= 1'b0;
      id_idx   <= '0;
      half     <= 1'b0;
      rd_byte  <= '0;
      wr_hi    <= '0;
      sio_o    <= '0;
      sio_oe   <= 1'b0;
    end else begin
      sck_d <= sck;
      if (ce_n) begin
        cnt     <= '0;
        half    <= 1'b0;
        id_mode <= 1'b0;
        sio_o   <= '0;
        sio_oe  <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            cnt  <= '0;
            half <= 1'b0;
          end
          CMD: begin
            if (rise) begin
              cmd_hi <= sio_i;
              cnt    <= cmd_last ? '0 : cnt + 8'd1;
              if (cmd_last) begin
                is_write <= (cmd_byte == 8'h38);
                id_mode  <= 1'b0;
`ifdef QSPI_PSRAM_TARGET_READID_EN
                if (cmd_byte == 8'h9F) begin
                  id_mode <= 1'b1;
                  id_idx  <= '0;
                  rd_byte <= id_byte(2'd0);
                  half    <= 1'b0;
                end
`endif
              end
            end
          end
          ADR: begin
            if (rise) begin
              adr <= adr_shift;
              cnt <= adr_last ? '0 : cnt + 8'd1;
              if (adr_last && !is_write && (WAIT_CYC == 0)) begin
                rd_byte <= mem[adr_shift];
                half    <= 1'b0;
              end
            end
          end
          WAIT: begin
            if (rise) begin
              cnt <= wait_last ? '0 : cnt + 8'd1;
              if (wait_last) begin
                rd_byte <= mem[adr];
                half    <= 1'b0;
              end
            end
          end
          RDATA: begin
            if (fall) begin
              sio_oe <= 1'b1;
              if (!half) begin
                sio_o <= rd_byte[7:4];
                half  <= 1'b1;
              end else begin
                sio_o <= rd_byte[3:0];
                half  <= 1'b0;
                // Next byte is fetched now; the following fall is at
                // least two clk away.
                if (id_mode) begin
                  id_idx  <= (id_idx == 2'd2) ? id_idx : id_idx + 2'd1;
                  rd_byte <= id_byte(id_idx + 2'd1);
                end else begin
                  adr     <= adr_inc;
                  rd_byte <= mem[adr_inc];
                end
              end
            end
          end
          WDATA: begin
            if (rise) begin
              if (!half) begin
                wr_hi <= sio_i;
                half  <= 1'b1;
              end else begin
                half <= 1'b0;
                adr  <= adr_inc;
              end
            end
          end
          default: ;
        endcase
      end
    end
  end

  // Memory contents are deliberately not reset.
  always_ff @(posedge clk) begin
    if (mem_we) mem[adr] <= {wr_hi, sio_i};
  end

endmodule

// File: tb/tb_qspi_psram_target.sv
module tb_qspi_psram_target;

  localparam int unsigned ADR_W    = 16;
  localparam int unsigned WAIT_CYC = 6;
  localparam int unsigned MEM_N    = 1 << ADR_W;

  logic       clk   = 1'b0;
  logic       rst   = 1'b1;
  logic       sck   = 1'b0;
  logic       ce_n  = 1'b1;
  logic [3:0] sio_i = 4'h0;
  logic [3:0] sio_o;
  logic       sio_oe;
  logic       busy;

  qspi_psram_target #(
    .ADR_W   (ADR_W),
    .WAIT_CYC(WAIT_CYC),
    .MFID    (8'h0D),
    .KGD     (8'h5D)
  ) dut (
    .clk   (clk),
    .rst   (rst),
    .sck   (sck),
    .ce_n  (ce_n),
    .sio_i (sio_i),
    .sio_o (sio_o),
    .sio_oe(sio_oe),
    .busy  (busy)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  bit chk_on = 1'b0;
  bit oe_seen = 1'b0;

  // Expected outputs after the most recent clk edge (exp_*) and after the
  // upcoming edge (nxt_*), derived from the transaction-level model.
  logic       exp_busy = 1'b0, exp_oe = 1'b0, exp_pop = 1'b0;
  logic [3:0] exp_o = 4'h0;
  logic       nxt_busy = 1'b0, nxt_oe = 1'b0, nxt_pop = 1'b0;
  logic [3:0] nxt_o = 4'h0;
  logic       prev_sck = 1'b0;
  bit         rd_active = 1'b0;

  logic [3:0] rd_q[$];
  logic [3:0] act_q[$];
  logic [7:0] rd_bytes[$];
  logic [7:0] wr_data[$];
  logic [7:0] mem_model[int];

  typedef struct {
    int unsigned a;
    int unsigned n;
  } region_t;
  region_t regions[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_on) begin
      chk("busy", busy, exp_busy);
      chk("sio_oe", sio_oe, exp_oe);
      chk("sio_o", sio_o, exp_o);
      if (exp_pop) act_q.push_back(sio_o);
      if (sio_oe === 1'b1) oe_seen = 1'b1;
    end
  end

  // One clk of stimulus: inputs for the next edge plus the outputs that
  // edge must produce.
  task automatic step(input logic ce, input logic s, input logic [3:0] d);
    @(posedge clk);
    #1;
    exp_busy = nxt_busy;
    exp_oe   = nxt_oe;
    exp_o    = nxt_o;
    exp_pop  = nxt_pop;
    ce_n     = ce;
    sck      = s;
    sio_i    = d;
    nxt_pop  = 1'b0;
    nxt_busy = !ce;
    if (ce) begin
      nxt_oe    = 1'b0;
      nxt_o     = 4'h0;
      rd_active = 1'b0;
      rd_q.delete();
    end else if (rd_active && !s && prev_sck) begin
      if (rd_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL rd_model_underflow: got 0 expected nibble at %0t", $time);
      end else begin
        nxt_o   = rd_q.pop_front();
        nxt_oe  = 1'b1;
        nxt_pop = 1'b1;
      end
    end
    prev_sck = s;
  endtask

  task automatic cyc(input logic [3:0] d);
    int unsigned h;
    h = $urandom_range(2, 3);
    repeat (h) step(1'b0, 1'b0, d);
    h = $urandom_range(2, 3);
    repeat (h) step(1'b0, 1'b1, d);
  endtask

  task automatic begin_tx();
    repeat ($urandom_range(1, 2)) step(1'b0, 1'b0, 4'h0);
  endtask

  task automatic end_tx();
    step(1'b1, 1'b1, 4'h0);
    repeat ($urandom_range(2, 4)) step(1'b1, 1'b0, 4'h0);
  endtask

  task automatic send_byte(input logic [7:0] b);
    cyc(b[7:4]);
    cyc(b[3:0]);
  endtask

  task automatic send_adr(input logic [23:0] a);
    for (int unsigned k = 0; k < 6; k++) cyc(a[4*(5-k) +: 4]);
  endtask

  task automatic rnd_cycles(input int unsigned n);
    repeat (n) cyc(4'($urandom_range(0, 15)));
  endtask

  task automatic do_write(input logic [23:0] a, input bit odd, input logic [3:0] odd_nib);
    int unsigned base;
    base = int'(a[ADR_W-1:0]);
    begin_tx();
    send_byte(8'h38);
    send_adr(a);
    for (int unsigned i = 0; i < wr_data.size(); i++) begin
      send_byte(wr_data[i]);
      mem_model[int'((base + i) % MEM_N)] = wr_data[i];
    end
    if (odd) cyc(odd_nib);
    end_tx();
    if (wr_data.size() > 0) regions.push_back('{a: base, n: wr_data.size()});
  endtask

  task automatic do_read(input logic [23:0] a, input int unsigned n);
    int unsigned base;
    int          key;
    logic [7:0]  b;
    base = int'(a[ADR_W-1:0]);
    act_q.delete();
    rd_bytes.delete();
    begin_tx();
    send_byte(8'hEB);
    send_adr(a);
    rnd_cycles(WAIT_CYC);
    for (int unsigned i = 0; i < n; i++) begin
      key = int'((base + i) % MEM_N);
      if (!mem_model.exists(key)) begin
        n_cmp++;
        n_bad++;
        $display("FAIL rd_unknown_addr: got unwritten %0h expected written", key);
        b = 8'h00;
      end else begin
        b = mem_model[key];
      end
      rd_q.push_back(b[7:4]);
      rd_q.push_back(b[3:0]);
    end
    rd_active = 1'b1;
    rnd_cycles(2 * n);
    end_tx();
    chk("rd_nibble_count", act_q.size(), 2 * n);
    for (int unsigned i = 0; i < n; i++) begin
      if (2 * i + 1 < act_q.size()) rd_bytes.push_back({act_q[2*i], act_q[2*i+1]});
      else rd_bytes.push_back(8'h00);
    end
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // 1. reset with ce_n high
    step(1'b1, 1'b0, 4'h0);
    chk_on = 1'b1;
    step(1'b1, 1'b0, 4'h0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_oe", sio_oe, 1'b0);
    chk("rst_o", sio_o, 4'h0);
    #1 rst = 1'b0;
    repeat (3) step(1'b1, 1'b0, 4'h0);

    // 2. write A5 3C at 0x10, read it back
    wr_data = '{8'hA5, 8'h3C};
    do_write(24'h000010, 1'b0, 4'h0);
    chk("model_10", mem_model[16'h10], 8'hA5);
    chk("model_11", mem_model[16'h11], 8'h3C);
    do_read(24'h000010, 2);
    chk("t2_rd0", rd_bytes[0], 8'hA5);
    chk("t2_rd1", rd_bytes[1], 8'h3C);

    // 1b. reset pulse in RDATA; the earlier write must survive
    act_q.delete();
    begin_tx();
    send_byte(8'hEB);
    send_adr(24'h000010);
    rnd_cycles(WAIT_CYC);
    rd_q = '{4'hA, 4'h5, 4'h3, 4'hC};
    rd_active = 1'b1;
    cyc(4'h0);
    step(1'b0, 1'b0, 4'h0);
    chk("pre_rst_oe", sio_oe, 1'b1);
    #1 rst = 1'b1;
    #1;
    chk("midrst_oe", sio_oe, 1'b0);
    chk("midrst_busy", busy, 1'b0);
    chk("midrst_o", sio_o, 4'h0);
    exp_busy = 1'b0; exp_oe = 1'b0; exp_o = 4'h0; exp_pop = 1'b0;
    nxt_busy = 1'b0; nxt_oe = 1'b0; nxt_o = 4'h0; nxt_pop = 1'b0;
    rd_active = 1'b0;
    rd_q.delete();
    repeat (2) step(1'b1, 1'b0, 4'h0);
    #1 rst = 1'b0;
    repeat (2) step(1'b1, 1'b0, 4'h0);
    do_read(24'h000010, 2);
    chk("postrst_rd0", rd_bytes[0], 8'hA5);
    chk("postrst_rd1", rd_bytes[1], 8'h3C);

    // 3. wrap at the top of memory
    wr_data = '{8'h11, 8'h22};
    do_write(24'h00FFFF, 1'b0, 4'h0);
    chk("model_wrap", mem_model[0], 8'h22);
    do_read(24'h00FFFF, 2);
    chk("t3_rd0", rd_bytes[0], 8'h11);
    chk("t3_rd1", rd_bytes[1], 8'h22);

    // 4. odd trailing nibble is dropped
    wr_data = '{8'h44};
    do_write(24'h000021, 1'b0, 4'h0);
    wr_data = '{8'h7E};
    do_write(24'h000020, 1'b1, 4'h9);
    do_read(24'h000020, 2);
    chk("t4_rd0", rd_bytes[0], 8'h7E);
    chk("t4_rd1", rd_bytes[1], 8'h44);

    // 5. unknown command is skipped
    oe_seen = 1'b0;
    begin_tx();
    send_byte(8'h05);
    rnd_cycles(10);
    end_tx();
    chk("t5_no_drive", oe_seen, 1'b0);
    do_read(24'h000010, 2);
    chk("t5_rd0", rd_bytes[0], 8'hA5);
    chk("t5_rd1", rd_bytes[1], 8'h3C);

    // 6. read ID
    act_q.delete();
    oe_seen = 1'b0;
    begin_tx();
    send_byte(8'h9F);
`ifdef QSPI_PSRAM_TARGET_READID_EN
    rd_q = '{4'h0, 4'hD, 4'h5, 4'hD, 4'h0, 4'h0};
    rd_active = 1'b1;
`endif
    rnd_cycles(6);
    end_tx();
`ifdef QSPI_PSRAM_TARGET_READID_EN
    chk("id_count", act_q.size(), 6);
    if (act_q.size() >= 6) begin
      chk("id_mfid", {act_q[0], act_q[1]}, 8'h0D);
      chk("id_kgd", {act_q[2], act_q[3]}, 8'h5D);
      chk("id_pad", {act_q[4], act_q[5]}, 8'h00);
    end
`else
    chk("id_no_drive", oe_seen, 1'b0);
`endif

    // random traffic against the model
    for (int unsigned it = 0; it < 24; it++) begin
      int unsigned sel;
      logic [15:0] a16;
      region_t     r;
      sel = $urandom_range(0, 3);
      if (sel <= 1 || regions.size() == 0) begin
        a16 = ($urandom_range(0, 3) == 0) ? 16'($urandom_range(16'hFFFC, 16'hFFFF))
                                          : 16'($urandom);
        wr_data.delete();
        repeat ($urandom_range(1, 4)) wr_data.push_back(8'($urandom));
        do_write({8'($urandom), a16}, 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)));
      end else if (sel == 2) begin
        r = regions[$urandom_range(0, regions.size() - 1)];
        do_read({8'($urandom), 16'(r.a)}, $urandom_range(1, r.n));
      end else begin
        oe_seen = 1'b0;
        begin_tx();
        send_byte(8'h01 + 8'($urandom_range(0, 3)) * 8'h10);
        rnd_cycles($urandom_range(2, 8));
        end_tx();
        chk("rnd_skip_no_drive", oe_seen, 1'b0);
      end
    end

    repeat (3) step(1'b1, 1'b0, 4'h0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
